// File: rtl/pipelined_addsub.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// STAGES equal segments of 4-bit CLA groups; inter-segment carries travel through registers.
module pipelined_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int SEG = WIDTH / STAGES;
  localparam int GRP = SEG / 4;

  logic [STAGES-1:0] v_q, c_q, v_d, c_d;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  s_d [STAGES];
  logic              ovf_q, zero_q, cm_last, adv;

  // Returns {carry into segment MSB, segment carry out, segment sum}.
  function automatic logic [SEG+1:0] cla_seg(input logic [SEG-1:0] x,
                                             input logic [SEG-1:0] y,
                                             input logic           ci);
    logic [SEG-1:0] g, p, c;
    logic [GRP:0]   gc;
    logic [3:0]     gg, pp;
    g     = x & y;
    p     = x ^ y;
    c     = '0;
    gc    = '0;
    gc[0] = ci;
    for (int unsigned k = 0; k < GRP; k++) begin
      gg = g[4*k +: 4];
      pp = p[4*k +: 4];
      c[4*k]   = gc[k];
      c[4*k+1] = gg[0] | (pp[0] & gc[k]);
      c[4*k+2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & gc[k]);
      c[4*k+3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
               | (pp[2] & pp[1] & pp[0] & gc[k]);
      gc[k+1]  = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
               | (pp[3] & pp[2] & pp[1] & gg[0]) | ((&pp) & gc[k]);
    end
    return {c[SEG-1], gc[GRP], p ^ c};
  endfunction

  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = ovf_q;
  assign zero      = zero_q;

  // Each stage adds its own slice and forwards the full-width operand/sum words;
  // bits outside the active slice are pure pass-through, so only one SEG-bit CLA sits per stage.
  always_comb begin
    logic [WIDTH-1:0] sa, sb, ss;
    logic             ci, vi;
    logic [SEG+1:0]   r;
    cm_last = 1'b0;
    for (int unsigned s = 0; s < STAGES; s++) begin
      if (s == 0) begin
        sa = a;
        sb = b ^ {WIDTH{sub}};
        ss = '0;
        ci = sub;
        vi = in_valid;
      end else begin
        sa = a_q[s-1];
        sb = b_q[s-1];
        ss = s_q[s-1];
        ci = c_q[s-1];
        vi = v_q[s-1];
      end
      r = cla_seg(sa[s*SEG +: SEG], sb[s*SEG +: SEG], ci);
      ss[s*SEG +: SEG] = r[SEG-1:0];
      a_d[s] = sa;
      b_d[s] = sb;
      s_d[s] = ss;
      c_d[s] = r[SEG];
      v_d[s] = vi;
      if (s == STAGES - 1) cm_last = r[SEG+1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < STAGES; s++) begin
        a_q[s] <= '0;
        b_q[s] <= '0;
        s_q[s] <= '0;
      end
      v_q    <= '0;
      c_q    <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (adv) begin
      for (int unsigned s = 0; s < STAGES; s++) begin
        a_q[s] <= a_d[s];
        b_q[s] <= b_d[s];
        s_q[s] <= s_d[s];
      end
      v_q    <= v_d;
      c_q    <= c_d;
      ovf_q  <= cm_last ^ c_d[STAGES-1];
      zero_q <= ~|s_d[STAGES-1];
    end
  end

endmodule

// File: doc/pipelined_addsub.md
# pipelined_addsub

Parametrised, pipelined carry-lookahead adder/subtractor with a valid/ready handshake. It is the clocked successor to the team's 32-bit two-level CLA adder and replaces its modelled `#1` output delay with real pipeline registers. The datapath is split into `STAGES` equal segments, and the carry ripples between segments through registers. It also adds subtract mode and status flags, and sits between operand issue and the ALU result mux.

## Interface
Parameters:
- `WIDTH`, default 32: operand and result width. Must be a multiple of `4*STAGES`.
- `STAGES`, default 2: number of pipeline segments and the latency in cycles. Legal range is 1..8.

Ports:
- `clk`  in  1  clock. All state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  operands present.
- `in_ready`  out  1  block can accept operands this cycle.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B.
- `sub`  in  1  0: A+B; 1: A-B.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer takes the result this cycle.
- `sum`  out  WIDTH  result, mod 2^WIDTH.
- `cout`  out  1  carry out of the MSB. In subtract mode, 1 means no borrow (A ≥ B unsigned).
- `ovf`  out  1  signed two's-complement overflow.
- `zero`  out  1  `sum` == 0.

## Operation
- **Segmentation.** SEG = WIDTH/STAGES. Stage s computes bits [s*SEG+SEG-1 : s*SEG].
  - Each stage is built from 4-bit CLA groups with a group-lookahead unit, the same structure as the existing CLA4 and CLA_processor.
  - Carry-in of stage 0 is `sub`. Carry-in of stage s>0 is the registered carry-out of stage s-1.
- **Operand preparation.** B is XORed with `{WIDTH{sub}}` at the input.
  - The upper, not-yet-added operand slices are carried forward in skew registers.
  - Completed lower sum slices are carried forward alongside them.
- **Valid tracking.** Each stage register holds a valid bit, and `out_valid` is the valid bit of the last stage.
- **Global advance.** `adv = !out_valid || out_ready`.
  - When `adv` = 1, every stage register loads from its predecessor. Stage 0 loads the inputs and `in_valid`.
  - When `adv` = 0, all stages hold.
  - `in_ready = adv`. This is combinational from `out_ready` and `out_valid`, and it does not depend on `in_valid`.
- **Transfers.** A transfer in occurs when `in_valid && in_ready`. A transfer out occurs when `out_valid && out_ready`.
- **Bubbles.** Bubbles advance with the pipeline and are not squeezed out. Throughput is one operation per cycle when `out_ready` is held high.
- **Flags.** All flags are registered with the final stage and align with `sum`.
  - `cout` is the final-stage carry-out.
  - `ovf = (a[MSB] == b'[MSB]) && (sum[MSB] != a[MSB])`, where b' is the inverted B in subtract mode. It is equivalent to the carry into the MSB XOR `cout`.
  - `zero = ~|sum`.
- **Stable outputs.** While `out_valid` && !`out_ready`, `sum`, `cout`, `ovf` and `zero` are held stable.
- **Invalid slots.** Data in invalid slots is don't-care to the consumer, but it must still be reset to 0.

## Timing
- **Reset.** While `rst_n` = 0, asynchronously:
  - all valid bits, data, skew and carry registers are 0;
  - `out_valid` = 0, `sum` = 0, `cout` = 0, `ovf` = 0, `zero` = 0;
  - `in_ready` = 1, because `out_valid` = 0.
- **Reset mid-operation.** All in-flight operations are discarded with no partial output. The first transfer after deassertion behaves as from empty.
- **Latency.** An operation accepted at rising edge N has `out_valid` = 1 from edge N+STAGES-1 onward, i.e. STAGES cycles after the accepting cycle. With STAGES=1 the result is visible right after the accepting edge.
- **Simultaneous transfers.** A transfer in and a transfer out may occur in the same cycle. Both complete, and the pipeline remains full.
- **Backpressure.** With the pipeline full and `out_ready` = 0, `in_ready` drops the same cycle. No operand is lost or duplicated.
- **Combinational depth.** The longest combinational path per stage is one SEG-bit CLA. No path crosses stages except the `in_ready`/`out_ready` path.
- **Wrap-around.** `sum` wraps mod 2^WIDTH. Carry and overflow are reported only through `cout` and `ovf`.

## Test plan
1. **Add with carry.** WIDTH=32, STAGES=2, a=0xFFFF_FFFF, b=0x0000_0001, sub=0, `out_ready` held 1.
   - Expect `sum`=0, `cout`=1, `ovf`=0, `zero`=1.
   - `out_valid` rises 2 cycles after acceptance.
2. **Subtract with borrow and overflow.** a=0x8000_0000, b=0x0000_0001, sub=1.
   - Expect `sum`=0x7FFF_FFFF, `cout`=1, `ovf`=1, `zero`=0.
   - Then a=3, b=5, sub=1: expect `sum`=0xFFFF_FFFE, `cout`=0, `ovf`=0.
3. **Streaming across a segment boundary.** Issue 100 back-to-back random operations with `out_ready`=1.
   - Results must match a reference model in order, one per cycle.
   - Include a=0x0000_FFFF, b=1 so the carry crosses the segment boundary, giving `sum`=0x0001_0000.
4. **Backpressure.** Fill the pipeline, then hold `out_ready`=0 for 5 cycles.
   - `in_ready`=0, and `sum`/flags are stable throughout.
   - On release, results drain in order with no loss or duplication.
   - A transfer in and a transfer out on the same cycle both complete.
5. **Asynchronous reset mid-flight.** Assert `rst_n`=0 with the pipeline full.
   - Outputs go to 0 and `out_valid`=0 immediately, without waiting for `clk`.
   - After release, a fresh operation completes with normal latency.
6. **Parameter sweep.** Rerun scenarios 1–3 for (WIDTH, STAGES) = (32,1), (64,4) and (16,4). Results must be identical to the model, with latency equal to STAGES.
